// File: rtl/mr_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : mr_wb_uart_tx
// Brief  : Pipelined Wishbone slave UART transmitter (8N1) with TX FIFO,
//          programmable bit period and level completion interrupt.
// Rev    : 1.0 - initial release
// ============================================================================
module mr_wb_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  addr_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] dat_o,
  output logic        stall_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST  = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic          ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]   dat_q, dat_d;
  logic          tx_en_q, tx_en_d, irq_en_q, irq_en_d;
  logic [15:0]   div_q, div_d, div_wr;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  logic accept, full, empty, busy, txdata_wr, push, pop;
  logic unused_ok;

  assign accept    = stb_i & cyc_i;
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != ST_IDLE);
  assign txdata_wr = accept & we_i & (addr_i == 2'd0) & sel_i[0];
  // Full is judged on the pre-cycle count, so a same-cycle pop never rescues a push.
  assign push      = txdata_wr & ~full;
  assign div_wr    = {sel_i[1] ? dat_i[15:8] : div_q[15:8],
                      sel_i[0] ? dat_i[7:0]  : div_q[7:0]};
  assign unused_ok = ^{dat_i[31:16], sel_i[3:2]};

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign dat_o   = dat_q;
  assign irq_o   = irq_q;
  assign stall_o = 1'b0;

  always_comb begin
    ack_d    = accept & ~(txdata_wr & full);
    err_d    = txdata_wr & full;
    dat_d    = '0;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    if (accept && !we_i) begin
      case (addr_i)
        2'd1:    dat_d = {16'h0, 8'(count_q), 5'b0, busy, empty, full};
        2'd2:    dat_d = {30'b0, irq_en_q, tx_en_q};
        2'd3:    dat_d = {16'h0, div_q};
        default: dat_d = '0;
      endcase
    end
    if (accept && we_i && addr_i == 2'd2 && sel_i[0]) begin
      tx_en_d  = dat_i[0];
      irq_en_d = dat_i[1];
    end
    if (accept && we_i && addr_i == 2'd3) begin
      div_d = (div_wr == 16'h0) ? 16'h1 : div_wr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_o    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = div_q;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_o = 1'b0;
        if (cnt_q == 16'h0) begin
          cnt_d   = div_q;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        tx_o = shift_q[0];
        if (cnt_q == 16'h0) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        if (cnt_q == 16'h0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = dat_i[7:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    irq_d = irq_en_q & empty & ~busy;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      div_q    <= DIV_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      div_q    <= div_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mr_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_mr_wb_uart_tx
// Brief  : Directed self-checking bench for mr_wb_uart_tx.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mr_wb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_i = '0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o, err_o, stall_o, tx_o, irq_o;
  logic [31:0] dat_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        r_ack, r_err;
  logic [31:0] r_dat;

  always #5 clk = ~clk;

  mr_wb_uart_tx #(.CLK_DIV(16), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .sel_i(sel_i),
    .dat_i(dat_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .err_o(err_o),
    .dat_o(dat_o), .stall_o(stall_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  // Called 1 time unit after a rising edge; returns in the response cycle.
  task automatic bus_req(input logic [1:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d);
    addr_i = a; we_i = w; sel_i = s; dat_i = d; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk); #1;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; sel_i = '0; dat_i = '0;
    r_ack = ack_o; r_err = err_o; r_dat = dat_o;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Starts on the first start-bit cycle; ends on the cycle after the stop bit.
  task automatic sample_frame(input int div, output logic [9:0] bits, output logic bad);
    logic prev;
    bad = 1'b0; bits = '0; prev = 1'b1;
    for (int i = 0; i < 10*(div+1); i++) begin
      if (i % (div+1) == 0) bits[i/(div+1)] = tx_o;
      else if (tx_o !== prev) bad = 1'b1;
      prev = tx_o;
      step(1);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    n_checks++;
    if ({ack_o, err_o, stall_o, tx_o, irq_o, dat_o} !== {5'b00010, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b err=%b stall=%b tx=%b irq=%b dat=%h, want 0 0 0 1 0 0",
               ack_o, err_o, stall_o, tx_o, irq_o, dat_o);
    end
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_ack !== 1'b1 || r_dat !== 32'h0000_0002) begin
      n_fail++; $display("FAIL reset_status: ack=%b dat=%h, want 1 00000002", r_ack, r_dat);
    end
    bus_req(2'd2, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000001", r_dat); end
    bus_req(2'd3, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'hf) begin n_fail++; $display("FAIL reset_div: got %h want 0000000f", r_dat); end
  endtask

  task automatic test_single_frame;
    logic [9:0] bits;
    logic bad;
    bus_req(2'd3, 1'b1, 4'b0011, 32'h3);
    bus_req(2'd3, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h3) begin n_fail++; $display("FAIL div_readback: got %h want 00000003", r_dat); end
    bus_req(2'd0, 1'b1, 4'b0001, 32'hA5);
    n_checks++;
    if ({r_ack, r_err, tx_o} !== 3'b101) begin
      n_fail++; $display("FAIL txdata_ack: ack=%b err=%b tx=%b, want 1 0 1", r_ack, r_err, tx_o);
    end
    step(1);
    n_checks++;
    if ({ack_o, tx_o} !== 2'b00) begin
      n_fail++; $display("FAIL start_latency: ack=%b tx=%b, want 0 0", ack_o, tx_o);
    end
    sample_frame(3, bits, bad);
    n_checks++;
    if (bits !== {1'b1, 8'hA5, 1'b0} || bad !== 1'b0 || tx_o !== 1'b1) begin
      n_fail++; $display("FAIL frame_a5: bits=%b glitch=%b tx_after=%b, want %b 0 1",
                         bits, bad, tx_o, {1'b1, 8'hA5, 1'b0});
    end
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h2) begin n_fail++; $display("FAIL status_after_frame: got %h want 00000002", r_dat); end
  endtask

  task automatic test_overflow;
    logic [9:0] bits;
    logic bad;
    logic [7:0] eb;
    int ok, gap_bad;
    ok = 0; gap_bad = 0;
    bus_req(2'd2, 1'b1, 4'b0001, 32'h0);
    for (int k = 0; k < 8; k++) begin
      eb = 8'h10 + 8'(k);
      bus_req(2'd0, 1'b1, 4'b0001, {24'h0, eb});
      if (r_ack === 1'b1 && r_err === 1'b0) ok++;
    end
    n_checks++;
    if (ok !== 8) begin n_fail++; $display("FAIL overflow_acks: got %0d want 8", ok); end
    bus_req(2'd0, 1'b1, 4'b0001, 32'h18);
    n_checks++;
    if ({r_ack, r_err} !== 2'b01) begin
      n_fail++; $display("FAIL overflow_err: ack=%b err=%b, want 0 1", r_ack, r_err);
    end
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h0000_0801) begin n_fail++; $display("FAIL status_full: got %h want 00000801", r_dat); end
    bus_req(2'd2, 1'b1, 4'b0001, 32'h1);
    step(1);
    for (int k = 0; k < 8; k++) begin
      eb = 8'h10 + 8'(k);
      sample_frame(3, bits, bad);
      n_checks++;
      if (bits !== {1'b1, eb, 1'b0} || bad !== 1'b0) begin
        n_fail++; $display("FAIL drain_frame%0d: bits=%b glitch=%b, want %b 0", k, bits, bad, {1'b1, eb, 1'b0});
      end
      if (k < 7) begin
        if (tx_o !== 1'b1) gap_bad++;
        step(1);
      end
    end
    n_checks++;
    if (gap_bad !== 0) begin n_fail++; $display("FAIL interframe_gap: %0d bad gaps want 0", gap_bad); end
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h2) begin n_fail++; $display("FAIL status_drained: got %h want 00000002", r_dat); end
  endtask

  task automatic test_irq;
    logic [9:0] bits;
    logic bad;
    bus_req(2'd3, 1'b1, 4'b0011, 32'h1);
    bus_req(2'd2, 1'b1, 4'b0001, 32'h3);
    step(3);
    n_checks++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_idle_high: got %b want 1", irq_o); end
    bus_req(2'd0, 1'b1, 4'b0001, 32'h3C);
    step(1);
    n_checks++;
    if ({irq_o, tx_o} !== 2'b00) begin
      n_fail++; $display("FAIL irq_push_low: irq=%b tx=%b, want 0 0", irq_o, tx_o);
    end
    sample_frame(1, bits, bad);
    n_checks++;
    if (bits !== {1'b1, 8'h3C, 1'b0} || bad !== 1'b0) begin
      n_fail++; $display("FAIL frame_3c_div1: bits=%b glitch=%b, want %b 0", bits, bad, {1'b1, 8'h3C, 1'b0});
    end
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_first_idle: got %b want 0", irq_o); end
    step(1);
    n_checks++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq_o); end
    bus_req(2'd2, 1'b1, 4'b0001, 32'h1);
    step(1);
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_disable: got %b want 0", irq_o); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] acks;
    logic tx_a2;
    int lows;
    bus_req(2'd3, 1'b1, 4'b0011, 32'h3);
    addr_i = 2'd0; we_i = 1'b1; sel_i = 4'b0001; dat_i = 32'h11; stb_i = 1'b1; cyc_i = 1'b1;
    step(1);
    acks[0] = ack_o; dat_i = 32'h22;
    step(1);
    acks[1] = ack_o; tx_a2 = tx_o; dat_i = 32'h33;
    step(1);
    acks[2] = ack_o;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; sel_i = '0; dat_i = '0;
    n_checks++;
    if (acks !== 3'b111 || tx_a2 !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back: acks=%b tx=%b, want 111 0", acks, tx_a2);
    end
    bus_req(2'd2, 1'b1, 4'b0001, 32'h0);
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h0000_0204) begin n_fail++; $display("FAIL status_midframe: got %h want 00000204", r_dat); end
    step(45);
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h0000_0200) begin n_fail++; $display("FAIL status_disabled: got %h want 00000200", r_dat); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_o !== 1'b1) lows++;
      step(1);
    end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL no_start_when_disabled: %0d low cycles want 0", lows); end
  endtask

  task automatic test_div_edges;
    bus_req(2'd3, 1'b1, 4'b0011, 32'h0);
    bus_req(2'd3, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h1) begin n_fail++; $display("FAIL div_zero_clamp: got %h want 00000001", r_dat); end
    bus_req(2'd3, 1'b1, 4'b0010, 32'h1234);
    bus_req(2'd3, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h1201) begin n_fail++; $display("FAIL div_high_lane: got %h want 00001201", r_dat); end
    bus_req(2'd3, 1'b1, 4'b0001, 32'hFF00);
    bus_req(2'd3, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h1200) begin n_fail++; $display("FAIL div_low_lane: got %h want 00001200", r_dat); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] bits;
    logic bad;
    bus_req(2'd2, 1'b1, 4'b0001, 32'h1);
    bus_req(2'd3, 1'b1, 4'b0011, 32'h3);
    bus_req(2'd0, 1'b1, 4'b0001, 32'hA5);
    step(1 + 17);
    n_checks++;
    if (tx_o !== 1'b0) begin n_fail++; $display("FAIL data_bit3: got %b want 0", tx_o); end
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    n_checks++;
    if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_abort_tx: got %b want 1", tx_o); end
    bus_req(2'd1, 1'b0, 4'hf, 32'h0);
    n_checks++;
    if (r_dat !== 32'h2) begin n_fail++; $display("FAIL reset_fifo_empty: got %h want 00000002", r_dat); end
    bus_req(2'd3, 1'b1, 4'b0011, 32'h3);
    bus_req(2'd0, 1'b1, 4'b0001, 32'h3C);
    step(1);
    sample_frame(3, bits, bad);
    n_checks++;
    if (bits !== {1'b1, 8'h3C, 1'b0} || bad !== 1'b0) begin
      n_fail++; $display("FAIL frame_after_reset: bits=%b glitch=%b, want %b 0", bits, bad, {1'b1, 8'h3C, 1'b0});
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_overflow;
    test_irq;
    test_back_to_back;
    test_div_edges;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
